pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_gen_pkg.sv | 12 +
 rtl/pulse_train_gen_phase_counter.sv | 27 ++
 rtl/pulse_train_gen.sv | 161 ++++++++++++++++
 tb/tb_pulse_train_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and default field width.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter with a zero flag; saturates at zero so it never wraps.
module phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: num pulses of width cycles high, separated by max(gap,1) cycles low.
// Optional abort input enabled by defining PULSE_TRAIN_GEN_ABORT_EN.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] num,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             sig_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [CNT_W-1:0] width_m1_q;
  logic [CNT_W-1:0] gap_m1_q;

  logic             req_ok;
  logic             ph_load, ph_dec, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             pl_load, pl_dec, pl_zero;
  logic [CNT_W-1:0] pl_val;

  assign req_ok = (width != '0) && (num != '0);

  // Counters hold "cycles remaining minus one", so a phase ends when its counter reads zero.
  always_comb begin
    ph_load = 1'b0;
    ph_dec  = 1'b0;
    ph_val  = '0;
    pl_load = 1'b0;
    pl_dec  = 1'b0;
    pl_val  = '0;
    case (state)
      IDLE: begin
        if (start && req_ok) begin
          ph_load = 1'b1;
          ph_val  = width - CNT_W'(1);
          pl_load = 1'b1;
          pl_val  = num - CNT_W'(1);
        end
      end
      HIGH: begin
        if (!ph_zero) begin
          ph_dec = 1'b1;
        end else if (!pl_zero) begin
          ph_load = 1'b1;
          ph_val  = gap_m1_q;
          pl_dec  = 1'b1;
        end
      end
      LOW: begin
        if (!ph_zero) begin
          ph_dec = 1'b1;
        end else begin
          ph_load = 1'b1;
          ph_val  = width_m1_q;
        end
      end
      default: ;
    endcase
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    if (abort && (state != IDLE)) begin
      ph_load = 1'b0;
      ph_dec  = 1'b0;
      pl_load = 1'b0;
      pl_dec  = 1'b0;
    end
`endif
  end

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .zero     (ph_zero)
  );

  phase_counter #(.CNT_W(CNT_W)) u_pulse (
    .clk      (clk),
    .rst      (rst),
    .load     (pl_load),
    .load_val (pl_val),
    .dec      (pl_dec),
    .zero     (pl_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      width_m1_q <= '0;
      gap_m1_q   <= '0;
      sig_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (req_ok) begin
              state      <= HIGH;
              width_m1_q <= width - CNT_W'(1);
              gap_m1_q   <= (gap == '0) ? '0 : gap - CNT_W'(1);
              sig_out    <= 1'b1;
              busy       <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (ph_zero) begin
            sig_out <= 1'b0;
            if (pl_zero) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (ph_zero) begin
            state   <= HIGH;
            sig_out <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          sig_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
`ifdef PULSE_TRAIN_GEN_ABORT_EN
      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        sig_out <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b0;
        err     <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen; abort checks compile in with PULSE_TRAIN_GEN_ABORT_EN.
module tb_pulse_train_gen;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] width;
  logic [W-1:0] gap;
  logic [W-1:0] num;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic         abort;
`endif
  logic         sig_out;
  logic         busy;
  logic         done;
  logic         err;

  int total = 0;
  int bad   = 0;

  pulse_train_gen #(.CNT_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .width   (width),
    .gap     (gap),
    .num     (num),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort   (abort),
`endif
    .sig_out (sig_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic b, input logic d, input logic e);
    chk({tag, ".sig_out"}, 32'(sig_out), 32'(s));
    chk({tag, ".busy"},    32'(busy),    32'(b));
    chk({tag, ".done"},    32'(done),    32'(d));
    chk({tag, ".err"},     32'(err),     32'(e));
  endtask

  // Drive a start in the current cycle T and advance to T+1.
  task automatic launch(input logic [W-1:0] w, input logic [W-1:0] g, input logic [W-1:0] n);
    start = 1'b1;
    width = w;
    gap   = g;
    num   = n;
    tick();
    start = 1'b0;
  endtask

  // Check cycles T+1..T+n; pattern bit n-1 is T+1. A stray start is pulsed in cycle index poke.
  task automatic expect_seq(input string tag, input int n, input logic [31:0] s,
                            input logic [31:0] b, input logic [31:0] d, input int poke);
    for (int i = 0; i < n; i++) begin
      chk_out($sformatf("%s[T+%0d]", tag, i + 1), s[n-1-i], b[n-1-i], d[n-1-i], 1'b0);
      if (i < n - 1) begin
        if (i == poke) begin
          start = 1'b1;
          width = 8'd7;
          gap   = 8'd7;
          num   = 8'd7;
        end
        tick();
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int highs;
    int rises;
    int cyc;
    logic prev;

    rst   = 1'b1;
    start = 1'b0;
    width = '0;
    gap   = '0;
    num   = '0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // width=3 gap=2 num=2
    launch(8'd3, 8'd2, 8'd2);
    expect_seq("w3g2n2", 9, 32'b111001110, 32'b111111110, 32'b000000001, -1);
    tick();
    chk_out("w3g2n2.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // width=1 gap=0 num=3: gap is stretched to one cycle
    launch(8'd1, 8'd0, 8'd3);
    expect_seq("w1g0n3", 6, 32'b101010, 32'b111110, 32'b000001, -1);
    tick();

    // rejected requests
    launch(8'd4, 8'd1, 8'd0);
    chk_out("num0", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("num0.after", 1'b0, 1'b0, 1'b0, 1'b0);
    launch(8'd0, 8'd1, 8'd3);
    chk_out("width0", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("width0.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // stray start at T+2 ignored; then a new start in the done cycle
    launch(8'd3, 8'd2, 8'd2);
    expect_seq("restart", 9, 32'b111001110, 32'b111111110, 32'b000000001, 1);
    launch(8'd1, 8'd0, 8'd1);
    chk_out("start_on_done", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("start_on_done.end", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // reset mid-train at T+4 of width=5 num=2
    launch(8'd5, 8'd1, 8'd2);
    expect_seq("rst_mid", 3, 32'b111, 32'b111, 32'b000, -1);
    tick();
    chk_out("rst_mid[T+4]", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("rst_mid[T+5]", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_out("rst_mid.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // reset wins over start
    rst = 1'b1;
    launch(8'd2, 8'd1, 8'd1);
    rst = 1'b0;
    chk_out("rst_vs_start", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst_vs_start.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // all-ones width: exactly 255 high cycles
    launch(8'd255, 8'd0, 8'd1);
    highs = 0;
    cyc   = 0;
    while (!done && cyc < 400) begin
      if (sig_out) highs++;
      tick();
      cyc++;
    end
    chk("w255.done_seen", 32'(done), 32'd1);
    chk("w255.high_cycles", 32'(highs), 32'd255);
    tick();

    // all-ones num: exactly 255 pulses, 509 busy cycles
    launch(8'd1, 8'd0, 8'd255);
    rises = 0;
    cyc   = 0;
    prev  = 1'b0;
    while (!done && cyc < 700) begin
      if (sig_out && !prev) rises++;
      prev = sig_out;
      tick();
      cyc++;
    end
    chk("n255.done_seen", 32'(done), 32'd1);
    chk("n255.pulses", 32'(rises), 32'd255);
    chk("n255.cycles", 32'(cyc), 32'd509);
    tick();

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    // abort at T+2
    launch(8'd4, 8'd1, 8'd3);
    expect_seq("abort", 2, 32'b11, 32'b11, 32'b00, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("abort[T+3]", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out("abort.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // abort while idle has no effect on an accepted start
    abort = 1'b1;
    launch(8'd2, 8'd0, 8'd1);
    abort = 1'b0;
    expect_seq("abort_idle", 3, 32'b110, 32'b110, 32'b001, -1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
